// File: rtl/modport_xfer_pkg.sv
// Shared constants and types for the modport_xfer fill-then-drain buffer.
// Optional feature: define MODPORT_XFER_REARM_EN to refill automatically after a full drain.
package modport_xfer_pkg;

  parameter int unsigned DataWDefault = 4;
  parameter int unsigned DepthDefault = 10;

  typedef logic [DataWDefault-1:0] word_t;

  // Address width for a DEPTH-entry array; a single entry still needs one address bit.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/modport_xfer_if.sv
// Producer/consumer bundle for modport_xfer: the producer drives prod_*,
// the buffer returns consumed words and status.
interface modport_xfer_if
  import modport_xfer_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned DEPTH  = DepthDefault
) ();

  localparam int unsigned PtrW = $clog2(DEPTH + 1);

  logic              prod_valid;
  logic [DATA_W-1:0] prod_data;
  logic              cons_valid;
  logic [DATA_W-1:0] cons_data;
  logic              full;
  logic              drained;
  logic [PtrW-1:0]   wr_count;

  modport master (
    output prod_valid,
    output prod_data,
    input  cons_valid,
    input  cons_data,
    input  full,
    input  drained,
    input  wr_count
  );

  modport slave (
    input  prod_valid,
    input  prod_data,
    output cons_valid,
    output cons_data,
    output full,
    output drained,
    output wr_count
  );

endinterface

// File: rtl/modport_xfer_mem.sv
// DEPTH x DATA_W storage with one write port and one registered read port.
// The read register holds its value when not enabled and clears on reset; the array is never reset.
module modport_xfer_mem
  import modport_xfer_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned DEPTH  = DepthDefault
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [addr_width(DEPTH)-1:0]  wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          rd_en,
  input  logic [addr_width(DEPTH)-1:0]  rd_addr,
  output logic [DATA_W-1:0]             rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/modport_xfer.sv
// Fill-then-drain buffer: produce calls fill DEPTH entries, further produce calls read them back
// in order. With MODPORT_XFER_REARM_EN the buffer empties and refills after the final read.
module modport_xfer
  import modport_xfer_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned DEPTH  = DepthDefault
) (
  input logic           master_clk1,
  input logic           rst,
  modport_xfer_if.slave bus
);

  localparam int unsigned PtrW  = $clog2(DEPTH + 1);
  localparam int unsigned AddrW = addr_width(DEPTH);

  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic            cons_valid_q;

  logic at_full;
  logic at_drained;
  logic wr_en;
  logic cons_req;
  logic rd_en;
  logic last_rd;

  assign at_full    = (wr_ptr_q == PtrW'(DEPTH));
  assign at_drained = (rd_ptr_q == PtrW'(DEPTH));

  // A produce call on a full buffer becomes a consume request instead of a write.
  assign wr_en    = bus.prod_valid && !at_full;
  assign cons_req = bus.prod_valid && at_full;
  assign rd_en    = cons_req && !at_drained;
  assign last_rd  = rd_en && (rd_ptr_q == PtrW'(DEPTH - 1));

`ifdef MODPORT_XFER_REARM_EN
  logic rearm_q;

  always_ff @(posedge master_clk1 or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cons_valid_q <= 1'b0;
      rearm_q      <= 1'b0;
    end else begin
      cons_valid_q <= rd_en;
      rearm_q      <= last_rd;
      // Write pointer clears with the final read; read pointer follows one edge later so
      // drained is visible for one cycle.
      if (last_rd) begin
        wr_ptr_q <= '0;
      end else if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rearm_q) begin
        rd_ptr_q <= '0;
      end else if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end
`else
  always_ff @(posedge master_clk1 or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cons_valid_q <= 1'b0;
    end else begin
      cons_valid_q <= rd_en;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  logic unused_last_rd;
  assign unused_last_rd = last_rd;
`endif

  modport_xfer_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (master_clk1),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q[AddrW-1:0]),
    .wr_data (bus.prod_data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q[AddrW-1:0]),
    .rd_data (bus.cons_data)
  );

  assign bus.cons_valid = cons_valid_q;
  assign bus.full       = at_full;
  assign bus.drained    = at_drained;
  assign bus.wr_count   = wr_ptr_q;

endmodule

// File: tb/tb_modport_xfer.sv
// Self-checking bench for modport_xfer: vector table for the fill/drain sequence, hand-written
// reset and gapped sequences, then random traffic against a queue-based reference model.
module tb_modport_xfer;
  import modport_xfer_pkg::*;

  localparam int unsigned DATA_W = DataWDefault;
  localparam int unsigned DEPTH  = DepthDefault;

  logic master_clk1;
  logic rst;

  modport_xfer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  modport_xfer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .master_clk1 (master_clk1),
    .rst         (rst),
    .bus         (bus.slave)
  );

  initial master_clk1 = 1'b0;
  always #5 master_clk1 = ~master_clk1;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: words in the order stored, and how many have been handed back.
  word_t stored[$];
  int    consumed;
  bit    m_valid;
  word_t m_data;
  bit    m_pending;

  typedef struct {
    logic  pv;
    word_t pd;
    logic  ev;
    word_t ed;
    logic  ef;
    logic  edr;
    int    ec;
  } vec_t;

  vec_t vecs[23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    stored.delete();
    consumed  = 0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_pending = 1'b0;
  endfunction

  function automatic void model_edge(input logic pv, input word_t pd);
    bit finished = 1'b0;
    m_valid = 1'b0;
    if (pv) begin
      if (stored.size() < DEPTH) begin
        stored.push_back(pd);
      end else if (consumed < DEPTH) begin
        m_valid  = 1'b1;
        m_data   = stored[consumed];
        consumed = consumed + 1;
        finished = (consumed == DEPTH);
      end
    end
`ifdef MODPORT_XFER_REARM_EN
    if (m_pending) consumed = 0;
    m_pending = finished;
    if (finished) stored.delete();
`else
    if (finished) m_pending = 1'b0;
`endif
  endfunction

  task automatic step(input logic pv, input word_t pd);
    bus.prod_valid = pv;
    bus.prod_data  = pd;
    @(posedge master_clk1);
    model_edge(pv, pd);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".cons_valid"}, 32'(bus.cons_valid), 32'(m_valid));
    check({tag, ".cons_data"},  32'(bus.cons_data),  32'(m_data));
    check({tag, ".full"},       32'(bus.full),       32'(stored.size() == DEPTH));
    check({tag, ".drained"},    32'(bus.drained),    32'(consumed == DEPTH));
    check({tag, ".wr_count"},   32'(bus.wr_count),   32'(stored.size()));
  endtask

  // Asynchronous reset pulse placed mid-cycle, checked before any clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_model(tag);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Vector table for the fill, drain and post-drain sequence.
    for (int i = 0; i < 10; i++) begin
      vecs[i] = '{pv: 1'b1, pd: word_t'(i), ev: 1'b0, ed: '0, ef: (i == 9), edr: 1'b0, ec: i + 1};
    end
    for (int j = 0; j < 10; j++) begin
      vecs[10 + j] = '{pv: 1'b1, pd: word_t'(10 + j), ev: 1'b1, ed: word_t'(j), ef: 1'b1,
                       edr: (j == 9), ec: 10};
`ifdef MODPORT_XFER_REARM_EN
      if (j == 9) begin
        vecs[10 + j].ef = 1'b0;
        vecs[10 + j].ec = 0;
      end
`endif
    end
    for (int k = 0; k < 3; k++) begin
`ifdef MODPORT_XFER_REARM_EN
      vecs[20 + k] = '{pv: 1'b1, pd: word_t'(k), ev: 1'b0, ed: word_t'(9), ef: 1'b0, edr: 1'b0,
                       ec: k + 1};
`else
      vecs[20 + k] = '{pv: 1'b1, pd: word_t'(k), ev: 1'b0, ed: word_t'(9), ef: 1'b1, edr: 1'b1,
                       ec: 10};
`endif
    end

    rst            = 1'b1;
    bus.prod_valid = 1'b0;
    bus.prod_data  = '0;
    model_reset();
    repeat (2) @(posedge master_clk1);
    #1;
    check("reset.cons_valid", 32'(bus.cons_valid), 0);
    check("reset.cons_data",  32'(bus.cons_data),  0);
    check("reset.full",       32'(bus.full),       0);
    check("reset.drained",    32'(bus.drained),    0);
    check("reset.wr_count",   32'(bus.wr_count),   0);
    rst = 1'b0;

    foreach (vecs[n]) begin
      step(vecs[n].pv, vecs[n].pd);
      check($sformatf("vec%0d.cons_valid", n), 32'(bus.cons_valid), 32'(vecs[n].ev));
      check($sformatf("vec%0d.cons_data", n),  32'(bus.cons_data),  32'(vecs[n].ed));
      check($sformatf("vec%0d.full", n),       32'(bus.full),       32'(vecs[n].ef));
      check($sformatf("vec%0d.drained", n),    32'(bus.drained),    32'(vecs[n].edr));
      check($sformatf("vec%0d.wr_count", n),   32'(bus.wr_count),   32'(vecs[n].ec));
    end

    // Abort a drain at read pointer 4, then refill and drain again.
    async_reset("pre31");
    for (int i = 0; i < 10; i++) step(1'b1, word_t'(i));
    for (int j = 0; j < 4; j++) begin
      step(1'b1, '0);
      check_model($sformatf("drain4_%0d", j));
    end
    async_reset("mid_drain_rst");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0);
      check("post_rst.cons_valid", 32'(bus.cons_valid), 0);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, word_t'(i));
      check_model($sformatf("refill%0d", i));
    end
    for (int j = 0; j < 10; j++) begin
      step(1'b1, word_t'(j + 5));
      check($sformatf("redrain%0d.data", j), 32'(bus.cons_data), j);
      check_model($sformatf("redrain%0d", j));
    end

    // Gapped producer: a request every other cycle.
    async_reset("pre_gap");
    for (int i = 0; i < 20; i++) begin
      step(1'b1, word_t'((i < 10) ? i : i + 10));
      check_model($sformatf("gap%0d.a", i));
      step(1'b0, word_t'(i));
      check_model($sformatf("gap%0d.b", i));
    end

    // Random traffic with occasional resets.
    async_reset("pre_rand");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0 || (consumed == DEPTH && $urandom_range(0, 5) == 0)) begin
        async_reset($sformatf("rand_rst%0d", i));
      end
      step(logic'($urandom_range(0, 3) != 0), word_t'($urandom));
      check_model($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
